// File: rtl/bat_loader_pkg.sv
// Shared types and constants for the BatAmateur byte-stream program loader.
package bat_loader_pkg;

  localparam int HDR_BYTES = 4;
  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 16;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_CNT_HI  = 4'd3,
    S_CNT_LO  = 4'd4,
    S_WORD_HI = 4'd5,
    S_WORD_LO = 4'd6,
    S_WRITE   = 4'd7,
    S_CSUM    = 4'd8,
    S_FIN     = 4'd9
  } state_t;

endpackage

// File: rtl/bat_loader.sv
// Framed byte-stream loader: holds the CPU halted and writes 16-bit words into program RAM.
// Optional trailing XOR checksum byte is enabled by defining BAT_LOADER_CHECKSUM_EN.
module bat_loader
  import bat_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [BYTE_W-1:0]        RX_DATA,
  input  logic                     RX_VALID,
  output logic                     RX_READY,
  output logic                     HALT,
  output logic                     RAM_EN,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic [WORD_W-1:0]        DATA,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERROR,
  output state_t                   state_dbg
);

  // Handshake: a byte moves on a rising edge where RX_VALID && RX_READY.
  // RX_READY depends only on registered state, never on RX_VALID.

`ifdef BAT_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_FIN;
`endif

  state_t                   state, state_nx;
  logic                     live;
  logic                     accept;
  logic [BYTE_W-1:0]        addr_hi;
  logic [BYTE_W-1:0]        cnt_hi;
  logic [WORD_W-1:0]        cnt;
  logic [WORD_W-1:0]        addr_full;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [WORD_W-1:0]        data_q;
  logic                     halt_q, busy_q, done_q;

  assign addr_full = {addr_hi, RX_DATA};
  assign accept    = RX_VALID && RX_READY;
  assign state_dbg = state;
  assign ADDRESS   = addr_q;
  assign DATA      = data_q;
  assign HALT      = halt_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RAM_EN    = (state == S_WRITE);

  // live keeps RX_READY low while reset is held and until the first edge after release.
  always_comb begin
    RX_READY = 1'b0;
    case (state)
      S_IDLE, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_WORD_HI, S_WORD_LO: RX_READY = live;
`ifdef BAT_LOADER_CHECKSUM_EN
      S_CSUM: RX_READY = live;
`endif
      default: RX_READY = 1'b0;
    endcase
  end

`ifdef BAT_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  logic              csum_ok;
  logic              error_q;

  assign csum_ok = (RX_DATA == csum);
  assign ERROR   = error_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      csum    <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept && state == S_IDLE) begin
        csum    <= RX_DATA;
        error_q <= 1'b0;
      end else if (accept && state != S_CSUM) begin
        csum <= csum ^ RX_DATA;
      end
      if (accept && state == S_CSUM && !csum_ok) error_q <= 1'b1;
    end
  end
`else
  assign ERROR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept) state_nx = S_ADDR_LO;
      S_ADDR_LO: if (accept) state_nx = S_CNT_HI;
      S_CNT_HI:  if (accept) state_nx = S_CNT_LO;
      S_CNT_LO:  if (accept) state_nx = ({cnt_hi, RX_DATA} == '0) ? S_TAIL : S_WORD_HI;
      S_WORD_HI: if (accept) state_nx = S_WORD_LO;
      S_WORD_LO: if (accept) state_nx = S_WRITE;
      S_WRITE:   state_nx = (cnt == 16'd1) ? S_TAIL : S_WORD_HI;
`ifdef BAT_LOADER_CHECKSUM_EN
      S_CSUM:    if (accept) state_nx = csum_ok ? S_FIN : S_IDLE;
`endif
      S_FIN:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      live    <= 1'b0;
      addr_hi <= '0;
      cnt_hi  <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      halt_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          addr_hi <= RX_DATA;
          done_q  <= 1'b0;
          busy_q  <= 1'b1;
          halt_q  <= 1'b1;
        end
        S_ADDR_LO: if (accept) addr_q <= addr_full[ADDRESS_WIDTH-1:0];
        S_CNT_HI:  if (accept) cnt_hi <= RX_DATA;
        S_CNT_LO:  if (accept) cnt <= {cnt_hi, RX_DATA};
        S_WORD_HI: if (accept) data_q[15:8] <= RX_DATA;
        S_WORD_LO: if (accept) data_q[7:0] <= RX_DATA;
        S_WRITE: begin
          addr_q <= addr_q + ADDRESS_WIDTH'(1);
          cnt    <= cnt - 16'd1;
        end
`ifdef BAT_LOADER_CHECKSUM_EN
        // A bad checksum ends the frame but leaves the CPU halted.
        S_CSUM: if (accept && !csum_ok) busy_q <= 1'b0;
`endif
        S_FIN: begin
          busy_q <= 1'b0;
          halt_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bat_loader.sv
// Directed bench for bat_loader: frame table with a write scoreboard plus hand-written corner sequences.
module tb_bat_loader;
  import bat_loader_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY, HALT, RAM_EN, BUSY, DONE, ERROR;
  logic [15:0] ADDRESS, DATA;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  bat_loader #(.ADDRESS_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .HALT(HALT), .RAM_EN(RAM_EN), .ADDRESS(ADDRESS), .DATA(DATA), .BUSY(BUSY),
    .DONE(DONE), .ERROR(ERROR), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] cnt;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
  } frame_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every RAM_EN pulse must match the head of exp_q.
  always @(negedge CLK) begin
    if (RST && RAM_EN) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h", ADDRESS, DATA);
      end else begin
        chk("write_addr_data", {ADDRESS, DATA}, exp_q.pop_front());
        chk("halt_during_write", {31'd0, HALT}, 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (!RX_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      chk("rx_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge CLK);
      @(negedge CLK);
    end
    RX_VALID = 1'b0;
  endtask

  function automatic logic [7:0] frame_csum(input logic [15:0] a, input logic [15:0] c,
                                            input logic [15:0] w0, input logic [15:0] w1);
    logic [7:0] x;
    x = a[15:8] ^ a[7:0] ^ c[15:8] ^ c[7:0];
    if (c >= 16'd1) x = x ^ w0[15:8] ^ w0[7:0];
    if (c >= 16'd2) x = x ^ w1[15:8] ^ w1[7:0];
    return x;
  endfunction

  task automatic send_frame(input logic [15:0] a, input logic [15:0] c,
                            input logic [15:0] w0, input logic [15:0] w1, input logic bad_sum);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
    if (c >= 16'd1) begin send_byte(w0[15:8]); send_byte(w0[7:0]); end
    if (c >= 16'd2) begin send_byte(w1[15:8]); send_byte(w1[7:0]); end
`ifdef BAT_LOADER_CHECKSUM_EN
    send_byte(frame_csum(a, c, w0, w1) ^ (bad_sum ? 8'hFF : 8'h00));
`else
    if (bad_sum) chk("bad_sum_without_feature", 32'd0, 32'd1);
`endif
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!DONE && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("done", {31'd0, DONE}, 32'd1);
    chk("halt_released", {31'd0, HALT}, 32'd0);
    chk("busy_clear", {31'd0, BUSY}, 32'd0);
    chk("error_clear", {31'd0, ERROR}, 32'd0);
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  frame_vec_t vecs[4];

  initial begin
    vecs[0] = '{16'h0010, 16'd2, 16'h1234, 16'hABCD, 16'h0010, 16'h0011};
    vecs[1] = '{16'hFFFF, 16'd2, 16'h5A5A, 16'h0F0F, 16'hFFFF, 16'h0000};
    vecs[2] = '{16'h0020, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{16'h1234, 16'd1, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000};

    // Reset values while held low.
    repeat (3) @(negedge CLK);
    chk("rst_rx_ready", {31'd0, RX_READY}, 32'd0);
    chk("rst_outputs", {HALT, RAM_EN, BUSY, DONE, ERROR}, 32'b10000);
    chk("rst_addr_data", {ADDRESS, DATA}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("ready_after_release", {31'd0, RX_READY}, 32'd1);
    chk("halt_after_release", {31'd0, HALT}, 32'd1);

    // First frame with exact release timing: RAM_EN, FIN, then HALT low with DONE high.
    exp_q.push_back({16'h0010, 16'h1234});
    exp_q.push_back({16'h0011, 16'hABCD});
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    chk("busy_in_frame", {31'd0, BUSY}, 32'd1);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
`ifdef BAT_LOADER_CHECKSUM_EN
    send_byte(frame_csum(16'h0010, 16'd2, 16'h1234, 16'hABCD));
    chk("fin_hold_halt", {30'd0, HALT, DONE}, 32'b10);
`else
    chk("ram_en_after_lo", {31'd0, RAM_EN}, 32'd1);
    @(negedge CLK);
    chk("fin_hold_halt", {29'd0, RAM_EN, HALT, DONE}, 32'b010);
`endif
    @(negedge CLK);
    chk("halt_fall_done_rise", {30'd0, HALT, DONE}, 32'b01);
    wait_done();

    // Table of frames; each restart must re-halt the CPU on the first accepted byte.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].cnt >= 16'd1) exp_q.push_back({vecs[i].exp_a0, vecs[i].w0});
      if (vecs[i].cnt >= 16'd2) exp_q.push_back({vecs[i].exp_a1, vecs[i].w1});
      send_byte(vecs[i].addr[15:8]);
      chk($sformatf("rehalt_v%0d", i), {29'd0, HALT, DONE, BUSY}, 32'b101);
      send_byte(vecs[i].addr[7:0]);
      send_byte(vecs[i].cnt[15:8]);
      send_byte(vecs[i].cnt[7:0]);
      if (vecs[i].cnt >= 16'd1) begin send_byte(vecs[i].w0[15:8]); send_byte(vecs[i].w0[7:0]); end
      if (vecs[i].cnt >= 16'd2) begin send_byte(vecs[i].w1[15:8]); send_byte(vecs[i].w1[7:0]); end
`ifdef BAT_LOADER_CHECKSUM_EN
      send_byte(frame_csum(vecs[i].addr, vecs[i].cnt, vecs[i].w0, vecs[i].w1));
`endif
      wait_done();
    end

    // RX_VALID stalls for 10 cycles between WORD_HI and WORD_LO.
    exp_q.push_back({16'h0050, 16'h7788});
    send_byte(8'h00); send_byte(8'h50); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h77);
    for (int k = 0; k < 10; k++) begin
      chk("stall_no_write", {31'd0, RAM_EN}, 32'd0);
      @(negedge CLK);
    end
    chk("stall_still_busy", {30'd0, BUSY, HALT}, 32'b11);
    send_byte(8'h88);
    chk("stall_write_pulse", {RAM_EN, ADDRESS, DATA[14:0]}, {1'b1, 16'h0050, 15'h7788});
    @(negedge CLK);
    chk("stall_single_pulse", {31'd0, RAM_EN}, 32'd0);
`ifdef BAT_LOADER_CHECKSUM_EN
    send_byte(frame_csum(16'h0050, 16'd1, 16'h7788, 16'h0000));
`endif
    wait_done();

`ifdef BAT_LOADER_CHECKSUM_EN
    // Bad checksum: word still written, ERROR set, CPU stays halted.
    exp_q.push_back({16'h0060, 16'h1234});
    send_frame(16'h0060, 16'd1, 16'h1234, 16'h0000, 1'b1);
    chk("csum_bad_flags", {28'd0, ERROR, HALT, DONE, BUSY}, 32'b1100);
    repeat (3) @(negedge CLK);
    chk("csum_bad_sticky", {29'd0, ERROR, HALT, DONE}, 32'b110);
    exp_q.push_back({16'h0070, 16'h4321});
    send_byte(8'h00);
    chk("error_cleared_on_hi", {31'd0, ERROR}, 32'd0);
    send_byte(8'h70); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h43); send_byte(8'h21);
    send_byte(frame_csum(16'h0070, 16'd1, 16'h4321, 16'h0000));
    wait_done();
`endif

    // Reset asserted while the WORD_LO byte is being offered: no write, reset values return.
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11);
    RX_DATA  = 8'h22;
    RX_VALID = 1'b1;
    RST      = 1'b0;
    @(negedge CLK);
    chk("midrst_outputs", {HALT, RAM_EN, BUSY, DONE, ERROR, RX_READY}, 32'b100000);
    chk("midrst_addr_data", {ADDRESS, DATA}, 32'd0);
    RX_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_ready_again", {30'd0, RX_READY, HALT}, 32'b11);
    repeat (4) @(negedge CLK);
    chk("midrst_no_write", {30'd0, RAM_EN, BUSY}, 32'b00);
    exp_q.push_back({16'h0080, 16'hCAFE});
    send_frame(16'h0080, 16'd1, 16'hCAFE, 16'h0000, 1'b0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
